// File: rtl/i_cache.sv
// rtl/i_cache.sv - direct-mapped read-only instruction cache, 4 words per line
//
// Ports:
//   Clk, Reset_N             clock, asynchronous active-low reset
//   cpu_readM, cpu_address   CPU fetch request and word address
//   cpu_data, cpu_ready      fetched word and its valid strobe (same-cycle on hit)
//   flush                    invalidate all lines / abort an outstanding fill
//   mem_readM, mem_address   line-fill request and line-aligned fill address
//   mem_data, mem_ready      fill line (word k at [16k+15:16k]) and its one-cycle strobe
//   hit_count, miss_count    saturating access statistics
module i_cache #(
    parameter int INDEX_BITS = 2
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        cpu_readM,
    input  logic [15:0] cpu_address,
    output logic [15:0] cpu_data,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_readM,
    output logic [15:0] mem_address,
    input  logic [63:0] mem_data,
    input  logic        mem_ready,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 14 - INDEX_BITS;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [63:0]             data_mem [LINES];
    // Word address of the missed line with the offset dropped; it is both the
    // fill address driven to memory and the source of the fill index and tag.
    logic [13:0]             fill_line;

    logic [INDEX_BITS-1:0]   req_index;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_BITS-1:0]   fill_index;
    logic [TAG_W-1:0]        fill_tag;
    logic                    lookup;
    logic                    hit;
    logic                    miss;
    logic                    fill_done;

    assign req_index  = cpu_address[INDEX_BITS+1:2];
    assign req_tag    = cpu_address[15:INDEX_BITS+2];
    assign fill_index = fill_line[INDEX_BITS-1:0];
    assign fill_tag   = fill_line[13:INDEX_BITS];

    // A flush in the same cycle suppresses the lookup entirely: no hit, no
    // miss, no fetch.
    assign lookup    = (state == IDLE) && cpu_readM && !flush;
    assign hit       = lookup && valid[req_index] && (tag_mem[req_index] == req_tag);
    assign miss      = lookup && !hit;
    // A flush coinciding with mem_ready wins: the returned line is discarded.
    assign fill_done = (state == FETCH) && mem_ready && !flush;

    assign cpu_ready   = hit;
    assign cpu_data    = hit ? data_mem[req_index][{cpu_address[1:0], 4'b0000} +: 16] : 16'h0000;
    assign mem_address = {fill_line, 2'b00};

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
            mem_readM  <= 1'b0;
            fill_line  <= 14'h0000;
        end else begin
            if (hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (miss) begin
                        state     <= FETCH;
                        mem_readM <= 1'b1;
                        fill_line <= cpu_address[15:2];
                    end
                end
                FETCH: begin
                    if (flush || mem_ready) begin
                        state     <= IDLE;
                        mem_readM <= 1'b0;
                    end
                    if (fill_done) begin
                        valid[fill_index] <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_readM <= 1'b0;
                end
            endcase

            // Placed last so it overrides any valid bit set by a fill.
            if (flush) begin
                valid <= '0;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge Clk) begin
        if (fill_done) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mem_data;
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// tb/tb_i_cache.sv - self-checking bench for i_cache
module tb_i_cache;

    localparam int IB    = 2;
    localparam int LINES = 1 << IB;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        cpu_readM = 1'b0;
    logic [15:0] cpu_address = 16'h0000;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        flush = 1'b0;
    logic        mem_readM;
    logic [15:0] mem_address;
    logic [63:0] mem_data = 64'h0;
    logic        mem_ready = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int failures = 0;

    i_cache #(.INDEX_BITS(IB)) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .cpu_readM(cpu_readM), .cpu_address(cpu_address),
        .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .flush(flush),
        .mem_readM(mem_readM), .mem_address(mem_address),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic        fl;
        logic        exp_ready;
        logic        chk_data;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    // Reference model: per-index valid/tag, contents derived from a fixed
    // word function of the address, and plain integer counters.
    logic        m_valid [LINES];
    int          m_tag   [LINES];
    int          m_hits;
    int          m_misses;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic present(input logic rd, input logic [15:0] addr, input logic fl);
        cpu_readM   = rd;
        cpu_address = addr;
        flush       = fl;
        #1;
    endtask

    task automatic do_reset();
        Reset_N   = 1'b0;
        cpu_readM = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        tick();
        Reset_N = 1'b1;
    endtask

    task automatic fill(input logic [63:0] ln);
        cpu_readM = 1'b0;
        mem_data  = ln;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic miss_at(input string name, input logic [15:0] addr, input logic [15:0] exp_ma);
        present(1'b1, addr, 1'b0);
        chk({name, "_ready"}, cpu_ready, 1'b0);
        tick();
        chk({name, "_mem_readM"}, mem_readM, 1'b1);
        chk({name, "_mem_address"}, mem_address, exp_ma);
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [63:0] line_of(input logic [15:0] base);
        logic [63:0] ln;
        for (int k = 0; k < 4; k++) ln[16*k +: 16] = word_of(base + 16'(k));
        return ln;
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        int idx = (a / 4) % LINES;
        int tg  = a / (4 * LINES);
        return m_valid[idx] && (m_tag[idx] == tg);
    endfunction

    initial begin
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h1111};
        vecs[1] = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 16'h2222};
        vecs[2] = '{1'b1, 16'h0012, 1'b0, 1'b1, 1'b1, 16'h3333};
        vecs[3] = '{1'b1, 16'h0013, 1'b0, 1'b1, 1'b1, 16'h4444};
        vecs[4] = '{1'b0, 16'h0013, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000};

        // Reset state
        tick();
        chk("rst_mem_readM", mem_readM, 1'b0);
        chk("rst_mem_address", mem_address, 16'h0000);
        chk("rst_hit_count", hit_count, 16'h0000);
        chk("rst_miss_count", miss_count, 16'h0000);
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        Reset_N = 1'b1;

        // Cold read, fill, re-read
        miss_at("cold", 16'h0012, 16'h0010);
        chk("cold_miss_count", miss_count, 16'd1);
        present(1'b1, 16'h0055, 1'b0);
        chk("fetch_ready", cpu_ready, 1'b0);
        fill(64'h4444_3333_2222_1111);
        chk("cold_after_fill_readM", mem_readM, 1'b0);
        present(1'b1, 16'h0012, 1'b0);
        chk("cold_hit_ready", cpu_ready, 1'b1);
        chk("cold_hit_data", cpu_data, 16'h3333);
        tick();
        chk("cold_hit_count", hit_count, 16'd1);
        chk("cold_miss_count2", miss_count, 16'd1);

        // Table: sequential hits, idle read, flush-with-read
        for (int i = 0; i < 6; i++) begin
            present(vecs[i].rd, vecs[i].addr, vecs[i].fl);
            chk($sformatf("vec%0d_ready", i), cpu_ready, vecs[i].exp_ready);
            if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), cpu_data, vecs[i].exp_data);
            tick();
        end
        flush = 1'b0;
        chk("tbl_hit_count", hit_count, 16'd5);
        chk("tbl_miss_count", miss_count, 16'd1);
        chk("tbl_no_fetch", mem_readM, 1'b0);
        miss_at("post_flush", 16'h0010, 16'h0010);
        fill(64'h0);

        // Conflict eviction
        do_reset();
        miss_at("conf_a", 16'h0000, 16'h0000);
        fill(line_of(16'h0000));
        miss_at("conf_b", 16'h0010, 16'h0010);
        fill(line_of(16'h0010));
        miss_at("conf_a2", 16'h0000, 16'h0000);
        fill(line_of(16'h0000));
        chk("conf_miss_count", miss_count, 16'd3);
        chk("conf_hit_count", hit_count, 16'd0);

        // Flush coinciding with mem_ready aborts the fill
        do_reset();
        miss_at("abort", 16'h0020, 16'h0020);
        mem_data  = line_of(16'h0020);
        mem_ready = 1'b1;
        flush     = 1'b1;
        cpu_readM = 1'b0;
        tick();
        mem_ready = 1'b0;
        flush     = 1'b0;
        chk("abort_readM", mem_readM, 1'b0);
        miss_at("abort_retry", 16'h0020, 16'h0020);
        chk("abort_miss_count", miss_count, 16'd2);
        fill(line_of(16'h0020));

        // Asynchronous reset mid-FETCH
        miss_at("arst", 16'h0034, 16'h0034);
        #2;
        Reset_N = 1'b0;
        #1;
        chk("arst_readM", mem_readM, 1'b0);
        chk("arst_hit_count", hit_count, 16'd0);
        chk("arst_miss_count", miss_count, 16'd0);
        chk("arst_mem_address", mem_address, 16'h0000);
        tick();
        Reset_N = 1'b1;
        miss_at("arst_after", 16'h0020, 16'h0020);
        fill(line_of(16'h0020));

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end
        m_hits = 0;
        m_misses = 0;
        for (int it = 0; it < 400; it++) begin
            logic [15:0] a;
            logic        rd, fl, exp_hit;
            a  = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 15));
            rd = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 19) == 0);
            mem_ready = !rd && ($urandom_range(0, 1) == 1);
            mem_data  = {$urandom, $urandom};
            present(rd, a, fl);
            exp_hit = rd && !fl && model_hit(a);
            chk("rnd_ready", cpu_ready, exp_hit);
            if (exp_hit) chk("rnd_data", cpu_data, word_of(a));
            if (!rd) chk("rnd_idle_data", cpu_data, 16'h0000);
            tick();
            mem_ready = 1'b0;
            if (fl) for (int k = 0; k < LINES; k++) m_valid[k] = 1'b0;
            if (exp_hit) begin
                if (m_hits < 65535) m_hits++;
            end else if (rd && !fl) begin
                logic [15:0] base;
                logic        ab;
                int          w;
                base = a & 16'hFFFC;
                if (m_misses < 65535) m_misses++;
                chk("rnd_mem_readM", mem_readM, 1'b1);
                chk("rnd_mem_address", mem_address, base);
                w = $urandom_range(0, 3);
                for (int c = 0; c < w; c++) begin
                    cpu_address = 16'($urandom);
                    cpu_readM   = 1'($urandom);
                    tick();
                    chk("rnd_wait_readM", mem_readM, 1'b1);
                    chk("rnd_wait_address", mem_address, base);
                end
                ab = ($urandom_range(0, 5) == 0);
                cpu_address = 16'($urandom);
                mem_data  = line_of(base);
                mem_ready = 1'b1;
                flush     = ab;
                tick();
                mem_ready = 1'b0;
                flush     = 1'b0;
                chk("rnd_fill_readM", mem_readM, 1'b0);
                if (ab) begin
                    for (int k = 0; k < LINES; k++) m_valid[k] = 1'b0;
                end else begin
                    m_valid[(base / 4) % LINES] = 1'b1;
                    m_tag[(base / 4) % LINES]   = base / (4 * LINES);
                end
            end
            chk("rnd_hit_count", hit_count, 16'(m_hits));
            chk("rnd_miss_count", miss_count, 16'(m_misses));
        end

        // Hit counter saturation
        do_reset();
        miss_at("sat", 16'h0040, 16'h0040);
        fill(line_of(16'h0040));
        present(1'b1, 16'h0041, 1'b0);
        repeat (65534) tick();
        chk("sat_fffe", hit_count, 16'hFFFE);
        repeat (3) tick();
        chk("sat_ffff", hit_count, 16'hFFFF);
        chk("sat_miss_count", miss_count, 16'd1);
        cpu_readM = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i_cache.md
I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 Parameter INDEX_BITS, default 2, number of line-index bits; the cache has 2^INDEX_BITS lines.
REQ-002 Port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port Reset_N, input, 1, asynchronous active-low reset.
REQ-004 Port cpu_readM, input, 1, CPU fetch request.
REQ-005 Port cpu_address, input, 16, CPU word address.
REQ-006 Port cpu_data, output, 16, fetched instruction word.
REQ-007 Port cpu_ready, output, 1, high when cpu_data is valid this cycle.
REQ-008 Port flush, input, 1, invalidates all lines.
REQ-009 Port mem_readM, output, 1, line-fill request to backing memory.
REQ-010 Port mem_address, output, 16, line-aligned fill address.
REQ-011 Port mem_data, input, 64, fill line; word k is at bits [16k+15:16k].
REQ-012 Port mem_ready, input, 1, single-cycle pulse marking mem_data valid.
REQ-013 Port hit_count, output, 16, saturating count of hits.
REQ-014 Port miss_count, output, 16, saturating count of misses.

Function
REQ-015 The cache shall be direct-mapped with 4 words per line: offset = addr[1:0], index = addr[INDEX_BITS+1:2], tag = addr[15:INDEX_BITS+2].
REQ-016 Each line shall hold a valid bit, a tag and 4 data words.
REQ-017 FSM states shall be IDLE and FETCH.
REQ-018 In IDLE, when cpu_readM=1 and the indexed line is valid with a matching tag, the access is a hit; cpu_ready=1 and cpu_data=word[offset] combinationally in the same cycle.
REQ-019 In IDLE, a hit shall increment hit_count at the clock edge, saturating at 16'hFFFF.
REQ-020 In IDLE, when cpu_readM=1 and the access is not a hit, the access is a miss; cpu_ready=0, miss_count increments at the edge (saturating at 16'hFFFF), and the FSM moves to FETCH.
REQ-021 On entering FETCH, the miss address shall be latched and mem_address = {addr[15:2], 2'b00} shall be held for the whole of FETCH.
REQ-022 mem_readM shall be 1 exactly while in FETCH.
REQ-023 cpu_ready shall be 0 throughout FETCH.
REQ-024 mem_ready is sampled only in FETCH and ignored in IDLE.
REQ-025 In FETCH with mem_ready=1, the fill shall write mem_data into the latched index, write the latched tag, set the valid bit, and return the FSM to IDLE.
REQ-026 After the fill, a re-presented request to the same address shall hit on the next cycle; the fill-to-hit latency is 1 cycle after the mem_ready edge.
REQ-027 When cpu_readM=0 in IDLE, cpu_ready=0, the counters shall hold, and no state changes.
REQ-028 When cpu_readM=0, cpu_data shall be 16'h0000.
REQ-029 While flush=1 at an edge, all valid bits shall be cleared.
REQ-030 flush=1 in FETCH shall abort the fill: the FSM returns to IDLE, no line is written even if mem_ready=1 in the same cycle, and mem_readM=0 from the next cycle.
REQ-031 flush=1 in IDLE with cpu_readM=1 shall report no hit (cpu_ready=0), count nothing, and not start a fetch.
REQ-032 A miss whose index evicts a valid line shall overwrite that line unconditionally (read-only cache, no write-back).
REQ-033 A change of cpu_address while in FETCH shall not alter mem_address or the fill target.

Reset
REQ-034 While Reset_N=0, asynchronously: FSM=IDLE, all valid bits=0, hit_count=0, miss_count=0, mem_readM=0, mem_address=0, cpu_ready=0.
REQ-035 Reset asserted during FETCH shall abandon the fill; after release, the first access to any address shall miss.
REQ-036 Tag and data arrays need not be reset.

Verification
REQ-037 Cold read 16'h0012: miss, mem_readM=1, mem_address=16'h0010; return mem_data=64'h4444_3333_2222_1111 -> the repeated request hits with cpu_data=16'h3333, hit_count=1, miss_count=1.
REQ-038 Sequential 16'h0010..16'h0013 after one fill -> 4 consecutive hits, 1 cycle each, data 1111/2222/3333/4444.
REQ-039 Conflict with INDEX_BITS=2: 16'h0000 then 16'h0010 then 16'h0000 -> 3 misses, the second fill of 16'h0000 refetched from mem_address=16'h0000.
REQ-040 flush asserted in FETCH in the same cycle as mem_ready -> FSM=IDLE, the line stays invalid, and the next access misses.
REQ-041 Reset_N pulsed low mid-FETCH (asynchronous, between edges) -> mem_readM=0 immediately and both counters=0.
REQ-042 Preload hit_count to 16'hFFFE via 3 further hits -> hit_count holds at 16'hFFFF.
